// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// FSM states, owner encoding and counter width.
package dmem_arb_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_P0 = 1'b0,
      OWN_P1 = 1'b1
   } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and SRAM bundle for dmem_arbiter.
// slave = arbiter side, master = requesters plus SRAM.
interface dmem_arbiter_if;

   logic        p0_req;
   logic        p0_we;
   logic [31:0] p0_addr;
   logic [31:0] p0_wdata;
   logic        p0_ack;
   logic [31:0] p0_rdata;
   logic        p0_stall;

   logic        p1_req;
   logic        p1_we;
   logic [31:0] p1_addr;
   logic [31:0] p1_wdata;
   logic        p1_ack;
   logic [31:0] p1_rdata;

   logic        mem_cs;
   logic        mem_oe;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      output p0_ack, p0_rdata, p0_stall,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      output p1_ack, p1_rdata,
      output mem_cs, mem_oe, mem_we,
      output mem_addr, mem_din,
      input  mem_dout
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      input  p0_ack, p0_rdata, p0_stall,
      output p1_req, p1_we, p1_addr, p1_wdata,
      input  p1_ack, p1_rdata,
      input  mem_cs, mem_oe, mem_we,
      input  mem_addr, mem_din,
      output mem_dout
   );

endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// Counts port-0 grants while port 1 waits.
// Saturates at MAX_WAIT; at_max_o forces the next grant to port 1.
module dmem_arb_starve_ctr
   import dmem_arb_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rstb,
   input  logic grant_p0_i,
   input  logic grant_p1_i,
   input  logic p1_req_i,
   output logic at_max_o
);

   logic [CNT_W-1:0] wait_q, wait_d;

   always_comb begin
      wait_d = wait_q;
      if (grant_p1_i || !p1_req_i) begin
         wait_d = '0;
      end else if (grant_p0_i &&
                   wait_q < CNT_W'(MAX_WAIT)) begin
         wait_d = wait_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) wait_q <= '0;
      else       wait_q <= wait_d;
   end

   assign at_max_o = (wait_q >= CNT_W'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port SRAM arbiter: pipeline port 0 over loader port 1.
// Define DMEM_ARB_STARVE_GUARD_EN to bound port-1 starvation.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ACC_CYCLES = 2,
   parameter int MAX_WAIT   = 4
) (
   input  logic           clk,
   input  logic           rstb,
   dmem_arbiter_if.slave  bus
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   owner_e           own_q, own_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      rd0_q, rd0_d;
   logic [31:0]      rd1_q, rd1_d;

   logic idle, access, done;
   logic force_p1, pick_p1;
   logic acc_p0, acc_p1;

   assign idle    = (state_q == ST_IDLE);
   assign access  = (state_q == ST_ACCESS);
   assign done    = (state_q == ST_DONE);
   assign pick_p1 = bus.p1_req &
                    (~bus.p0_req | force_p1);
   assign acc_p1  = idle & pick_p1;
   assign acc_p0  = idle & bus.p0_req & ~pick_p1;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   logic at_max;

   dmem_arb_starve_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk        (clk),
      .rstb       (rstb),
      .grant_p0_i (acc_p0),
      .grant_p1_i (acc_p1),
      .p1_req_i   (bus.p1_req),
      .at_max_o   (at_max)
   );

   assign force_p1 = at_max;
`else
   logic unused_max_wait;
   assign unused_max_wait = ^CNT_W'(MAX_WAIT);
   assign force_p1 = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      own_d   = own_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd0_d   = rd0_q;
      rd1_d   = rd1_q;
      unique case (state_q)
         ST_IDLE: begin
            if (acc_p0 || acc_p1) begin
               state_d = ST_ACCESS;
               cnt_d   = CNT_W'(ACC_CYCLES - 1);
               own_d   = acc_p1 ? OWN_P1 : OWN_P0;
               we_d    = acc_p1 ? bus.p1_we
                                : bus.p0_we;
               addr_d  = acc_p1 ? bus.p1_addr
                                : bus.p0_addr;
               wdata_d = acc_p1 ? bus.p1_wdata
                                : bus.p0_wdata;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
               if (!we_q) begin
                  if (own_q == OWN_P1) rd1_d = bus.mem_dout;
                  else                 rd0_d = bus.mem_dout;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         own_q   <= OWN_P0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd0_q   <= '0;
         rd1_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         own_q   <= own_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
      end
   end

   // Strobes are decoded from state so reset drops them at once.
   assign bus.mem_cs   = access;
   assign bus.mem_we   = access & we_q;
   assign bus.mem_oe   = access & ~we_q;
   assign bus.mem_addr = addr_q;
   assign bus.mem_din  = wdata_q;
   assign bus.p0_ack   = done & (own_q == OWN_P0);
   assign bus.p1_ack   = done & (own_q == OWN_P1);
   assign bus.p0_rdata = rd0_q;
   assign bus.p1_rdata = rd1_q;
   assign bus.p0_stall = bus.p0_req & ~bus.p0_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model plus
// directed vectors; a second instance runs ACC_CYCLES=1.
module tb_dmem_arbiter;

   localparam int ACC  = 2;
   localparam int MAXW = 4;

   logic clk = 1'b0;
   logic rstb;
   always #5 clk = ~clk;

   dmem_arbiter_if bus ();
   dmem_arbiter_if bus2 ();

   dmem_arbiter #(
      .ACC_CYCLES (ACC),
      .MAX_WAIT   (MAXW)
   ) dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus)
   );

   dmem_arbiter #(
      .ACC_CYCLES (1),
      .MAX_WAIT   (MAXW)
   ) dut2 (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus2)
   );

   function automatic logic [31:0] dout_fn(
      input logic [31:0] a);
      if (a == 32'h40) return 32'hDEADBEEF;
      return a * 32'd3 + 32'h1000_0001;
   endfunction

   assign bus.mem_dout  = dout_fn(bus.mem_addr);
   assign bus2.mem_dout = dout_fn(bus2.mem_addr);

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h",
                  nm, act, exp);
      end
   endtask

   // Transaction-level model: each accepted request owns the
   // SRAM for ACC cycles, acks in the next, then one idle cycle.
   int          cyc = 0;
   logic        m_busy;
   int          m_acc;
   logic        m_own;
   logic        m_we;
   logic [31:0] m_addr, m_din, m_rd0, m_rd1;
   int          m_wt;
   logic        m_free, m_pick1, m_guard;
   int          m_ph;
   logic        e_acc, e_done;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   assign m_guard = (m_wt >= MAXW);
`else
   assign m_guard = 1'b0;
`endif

   assign m_free  = !m_busy || (cyc >= m_acc + ACC + 2);
   assign m_pick1 = bus.p1_req && (!bus.p0_req || m_guard);
   assign m_ph    = cyc - 1 - m_acc;
   assign e_acc   = m_busy && m_ph >= 0 && m_ph < ACC;
   assign e_done  = m_busy && m_ph == ACC;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         m_busy <= 1'b0;
         m_acc  <= 0;
         m_own  <= 1'b0;
         m_we   <= 1'b0;
         m_addr <= '0;
         m_din  <= '0;
         m_rd0  <= '0;
         m_rd1  <= '0;
         m_wt   <= 0;
      end else begin
         if (m_busy && cyc == m_acc + ACC && !m_we) begin
            if (m_own) m_rd1 <= dout_fn(m_addr);
            else       m_rd0 <= dout_fn(m_addr);
         end
         if (m_free && (bus.p0_req || bus.p1_req)) begin
            m_busy <= 1'b1;
            m_acc  <= cyc;
            m_own  <= m_pick1;
            m_we   <= m_pick1 ? bus.p1_we : bus.p0_we;
            m_addr <= m_pick1 ? bus.p1_addr : bus.p0_addr;
            m_din  <= m_pick1 ? bus.p1_wdata : bus.p0_wdata;
         end else if (m_free) begin
            m_busy <= 1'b0;
         end
         if (!bus.p1_req)
            m_wt <= 0;
         else if (m_free && m_pick1)
            m_wt <= 0;
         else if (m_free && bus.p0_req && m_wt < MAXW)
            m_wt <= m_wt + 1;
      end
   end

   always @(negedge clk) begin
      if (rstb === 1'b1) begin
         chk("m_p0_ack", 32'(bus.p0_ack),
             32'(e_done && !m_own));
         chk("m_p1_ack", 32'(bus.p1_ack),
             32'(e_done && m_own));
         chk("m_p0_stall", 32'(bus.p0_stall),
             32'(bus.p0_req && !(e_done && !m_own)));
         chk("m_mem_cs", 32'(bus.mem_cs), 32'(e_acc));
         chk("m_mem_we", 32'(bus.mem_we),
             32'(e_acc && m_we));
         chk("m_mem_oe", 32'(bus.mem_oe),
             32'(e_acc && !m_we));
         chk("m_mem_addr", bus.mem_addr, m_addr);
         chk("m_mem_din", bus.mem_din, m_din);
         chk("m_p0_rdata", bus.p0_rdata, m_rd0);
         chk("m_p1_rdata", bus.p1_rdata, m_rd1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Single request; counts negedges from drive to ack.
   task automatic p_txn(input int port,
                        input logic we,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        output int lat,
                        output int ncs,
                        output int nwe,
                        output int noe,
                        output logic stall_ack);
      lat = -1; ncs = 0; nwe = 0; noe = 0;
      stall_ack = 1'b1;
      if (port == 0) begin
         bus.p0_req = 1'b1; bus.p0_we = we;
         bus.p0_addr = a;   bus.p0_wdata = d;
      end else begin
         bus.p1_req = 1'b1; bus.p1_we = we;
         bus.p1_addr = a;   bus.p1_wdata = d;
      end
      for (int k = 1; k <= 20 && lat < 0; k++) begin
         @(negedge clk);
         if (bus.mem_cs) ncs++;
         if (bus.mem_we) nwe++;
         if (bus.mem_oe) noe++;
         if (port == 0 ? bus.p0_ack : bus.p1_ack) begin
            lat = k;
            stall_ack = bus.p0_stall;
         end
      end
      tick();
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
   endtask

   int lat, ncs, nwe, noe, a0, a1, nack, ng;
   logic sa;
   logic [9:0] order;
   logic [9:0] exp_order;

   initial begin
      rstb = 1'b0;
      bus.p0_req = 0; bus.p0_we = 0;
      bus.p0_addr = 0; bus.p0_wdata = 0;
      bus.p1_req = 0; bus.p1_we = 0;
      bus.p1_addr = 0; bus.p1_wdata = 0;
      bus2.p0_req = 0; bus2.p0_we = 0;
      bus2.p0_addr = 0; bus2.p0_wdata = 0;
      bus2.p1_req = 0; bus2.p1_we = 0;
      bus2.p1_addr = 0; bus2.p1_wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_p0_rdata", bus.p0_rdata, 32'h0);
      chk("rst_p1_rdata", bus.p1_rdata, 32'h0);
      chk("rst_mem_cs", 32'(bus.mem_cs), 32'h0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_p0_ack", 32'(bus.p0_ack), 32'h0);
      #1;
      rstb = 1'b1;
      tick();

      // Port-0 read of 0x40
      p_txn(0, 1'b0, 32'h40, 32'h0,
            lat, ncs, nwe, noe, sa);
      chk("rd0_lat", 32'(lat), 32'd4);
      chk("rd0_cs_cycles", 32'(ncs), 32'd2);
      chk("rd0_oe_cycles", 32'(noe), 32'd2);
      chk("rd0_we_cycles", 32'(nwe), 32'd0);
      chk("rd0_stall_at_ack", 32'(sa), 32'd0);
      chk("rd0_rdata", bus.p0_rdata, 32'hDEADBEEF);

      // Port-1 write
      p_txn(1, 1'b1, 32'h80, 32'h12345678,
            lat, ncs, nwe, noe, sa);
      chk("wr1_lat", 32'(lat), 32'd4);
      chk("wr1_we_cycles", 32'(nwe), 32'd2);
      chk("wr1_oe_cycles", 32'(noe), 32'd0);
      chk("wr1_rdata_kept", bus.p1_rdata, 32'h0);
      chk("wr1_mem_din", bus.mem_din, 32'h12345678);
      chk("wr1_mem_addr", bus.mem_addr, 32'h80);
      chk("wr1_p0_rdata_kept", bus.p0_rdata, 32'hDEADBEEF);

      // Port-1 read
      p_txn(1, 1'b0, 32'h84, 32'h0,
            lat, ncs, nwe, noe, sa);
      chk("rd1_lat", 32'(lat), 32'd4);
      chk("rd1_rdata", bus.p1_rdata, 32'h1000018D);

      // Simultaneous requests, released as each acks
      a0 = -1; a1 = -1;
      bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h48;
      bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 32'h4C;
      for (int k = 1; k <= 30 && (a0 < 0 || a1 < 0); k++) begin
         @(negedge clk);
         if (bus.p0_ack) a0 = k;
         if (bus.p1_ack) a1 = k;
         tick();
         if (a0 > 0) bus.p0_req = 0;
         if (a1 > 0) bus.p1_req = 0;
      end
      bus.p0_req = 0; bus.p1_req = 0;
      chk("both_p0_ack_at", 32'(a0), 32'd4);
      chk("both_p1_ack_at", 32'(a1), 32'd8);
      chk("both_p0_rdata", bus.p0_rdata, 32'h100000D9);
      chk("both_p1_rdata", bus.p1_rdata, 32'h100000E5);

      // Both held continuously: grant order over 10 acks
      tick();
      order = '0; ng = 0;
      bus.p0_req = 1; bus.p0_addr = 32'h60;
      bus.p1_req = 1; bus.p1_addr = 32'h64;
      for (int k = 0; k < 100 && ng < 10; k++) begin
         @(negedge clk);
         if (bus.p1_ack) order[ng] = 1'b1;
         if (bus.p0_ack || bus.p1_ack) ng++;
      end
      tick();
      bus.p0_req = 0; bus.p1_req = 0;
`ifdef DMEM_ARB_STARVE_GUARD_EN
      exp_order = 10'b10_0001_0000;
`else
      exp_order = 10'b00_0000_0000;
`endif
      chk("held_grants", 32'(ng), 32'd10);
      chk("held_order", 32'(order), 32'(exp_order));

      // Reset in the middle of an access
      tick();
      bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h50;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_cs_before", 32'(bus.mem_cs), 32'd1);
      #1;
      rstb = 1'b0;
      #1;
      chk("rst_mid_cs", 32'(bus.mem_cs), 32'd0);
      chk("rst_mid_addr", bus.mem_addr, 32'h0);
      chk("rst_mid_rdata", bus.p0_rdata, 32'h0);
      bus.p0_req = 0;
      nack = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.p0_ack || bus.p1_ack) nack++;
      end
      chk("rst_mid_no_ack", 32'(nack), 32'd0);
      tick();
      rstb = 1'b1;
      tick();
      p_txn(0, 1'b0, 32'h54, 32'h0,
            lat, ncs, nwe, noe, sa);
      chk("post_rst_lat", 32'(lat), 32'd4);
      chk("post_rst_rdata", bus.p0_rdata, 32'h100000FD);

      // ACC_CYCLES=1 instance, request dropped mid-access
      tick();
      bus2.p0_req = 1; bus2.p0_we = 0; bus2.p0_addr = 32'h44;
      @(negedge clk);
      @(negedge clk);
      chk("a1_cs", 32'(bus2.mem_cs), 32'd1);
      bus2.p0_req = 0;
      @(negedge clk);
      chk("a1_ack", 32'(bus2.p0_ack), 32'd1);
      chk("a1_rdata", bus2.p0_rdata, 32'h100000CD);
      chk("a1_cs_done", 32'(bus2.mem_cs), 32'd0);
      @(negedge clk);
      chk("a1_ack_pulse", 32'(bus2.p0_ack), 32'd0);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ACC_CYCLES, default 2, SRAM access cycles per transaction (legal 1..15).
REQ-002 SHALL have parameter MAX_WAIT, default 4, consecutive port-0 grants allowed while port 1 waits (legal 1..15).
REQ-003 SHALL have ports, one per line:
 clk  in  1  single clock, all state on rising edge
 rstb  in  1  reset, asynchronous, active-low
 p0_req/p0_we  in  1/1  pipeline MEM-stage request / write
 p0_addr/p0_wdata  in  32/32  pipeline address / store data
 p0_ack  out  1  one-cycle completion pulse, port 0
 p0_rdata  out  32  port-0 load data, registered
 p0_stall  out  1  p0_req & ~p0_ack, pipeline hold
 p1_req/p1_we  in  1/1  loader/debug request / write
 p1_addr/p1_wdata  in  32/32  loader address / write data
 p1_ack  out  1  one-cycle completion pulse, port 1
 p1_rdata  out  32  port-1 read data, registered
 mem_cs/mem_oe/mem_we  out  1/1/1  SRAM chip select / output enable / write enable
 mem_addr/mem_din  out  32/32  SRAM address / write data
 mem_dout  in  32  SRAM read data

Function
REQ-004 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-005 IDLE: on any req, SHALL latch winner's owner, we, addr, wdata; load counter ACC_CYCLES-1; go ACCESS.
REQ-006 Arbitration SHALL be fixed priority, port 0 over port 1, except as REQ-016.
REQ-007 ACCESS: mem_cs=1, mem_we=latched we, mem_oe=~latched we, mem_addr/mem_din=latched values; counter decrements each cycle.
REQ-008 ACCESS with counter 0: read SHALL capture mem_dout into owner's rdata; write SHALL leave rdata unchanged; go DONE.
REQ-009 DONE: owner's ack SHALL be high exactly one cycle; mem_cs/oe/we low; go IDLE.
REQ-010 Latency: req sampled in IDLE at edge N -> ack high during cycle N+ACC_CYCLES+1; rdata valid with ack and held until next read by same port.
REQ-011 Requesters SHALL hold req and fields until ack; a request dropped mid-transaction SHALL still complete and ack.
REQ-012 New request SHALL not be accepted in DONE; back-to-back throughput one transaction per ACC_CYCLES+2 cycles.
REQ-013 IDLE/DONE: mem_cs, mem_oe, mem_we SHALL be 0; mem_addr/mem_din hold last latched values.
REQ-014 Owner/we/addr/wdata SHALL be latched only in IDLE; input changes during ACCESS SHALL not affect SRAM drive.

Reset
REQ-015 rstb low SHALL asynchronously force IDLE, counters 0, acks 0, rdata 0, latched addr/wdata/we/owner 0, mem_* outputs 0; reset mid-transaction SHALL abort with no ack.

Configuration
REQ-016 With DMEM_ARB_STARVE_GUARD_EN defined: wait counter increments on each port-0 grant while p1_req high; clears on port-1 grant or p1_req low; at MAX_WAIT, next IDLE arbitration SHALL grant port 1.
REQ-017 Without DMEM_ARB_STARVE_GUARD_EN: strict port-0 priority; wait counter and its logic absent.

Structure
REQ-018 Package dmem_arb_pkg SHALL hold FSM state enum, owner encoding (OWN_P0=0, OWN_P1=1), counter width constant.
REQ-019 One sub-module dmem_arb_starve_ctr (wait counter, saturating at MAX_WAIT) instantiated only under DMEM_ARB_STARVE_GUARD_EN.

Verification
REQ-020 Port-0 read, ACC_CYCLES=2, mem_dout=0xDEADBEEF for addr 0x40 -> mem_cs high 2 cycles, p0_ack 3 cycles after req edge, p0_rdata=0xDEADBEEF, p0_stall low with ack.
REQ-021 Port-1 write addr 0x80 data 0x12345678 -> mem_we=1, mem_oe=0 for 2 cycles, p1_ack pulse, p1_rdata unchanged.
REQ-022 p0_req and p1_req same cycle, guard off -> port 0 served first, port 1 acked next transaction.
REQ-023 Guard on, MAX_WAIT=4, both req held continuously -> grants P0,P0,P0,P0,P1, repeat.
REQ-024 rstb low during ACCESS -> no ack, mem_cs=0 immediately, FSM IDLE; request after release served normally.
REQ-025 ACC_CYCLES=1, p0 drops req mid-ACCESS -> transaction completes, p0_ack pulses 2 cycles after acceptance.
